// File: rtl/led_serial_param.sv
// Nibble-serial LED-64/LED-128 encryption core with configurable serial I/O width.
// Optional block counter output blk_cnt is enabled by defining LED_BLOCK_CNT_EN.
module led_serial_param #(
  parameter int KEY_BITS = 128,
  parameter int SERIAL_W = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SERIAL_W-1:0] keyi,
  input  logic [SERIAL_W-1:0] datai,
  output logic [SERIAL_W-1:0] dataq,
  input  logic                loadkey,
  input  logic                loadpt,
  input  logic                getct,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef LED_BLOCK_CNT_EN
  ,
  output logic [15:0]         blk_cnt
`endif
);

  generate
    if (!(KEY_BITS == 64 || KEY_BITS == 128)) begin : g_bad_key_bits
      $error("led_serial_param: KEY_BITS must be 64 or 128");
    end
    if (!(SERIAL_W == 1 || SERIAL_W == 2 || SERIAL_W == 4 || SERIAL_W == 8)) begin : g_bad_serial_w
      $error("led_serial_param: SERIAL_W must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int         STEPS     = (KEY_BITS == 64) ? 8 : 12;
  localparam logic [7:0] KS        = 8'(KEY_BITS);
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  // state     | meaning
  // IDLE      | accept start / loadkey / loadpt / getct
  // INIT      | initial AddRoundKey, 16 nibble shifts
  // SBOX      | AddConstants + SubCells, 16 nibble shifts
  // SHIFTROW  | row i rotated left by i nibbles, rc advanced
  // MIXCOL    | 4 columns x (4 compute + 1 rotate)
  // NEXTROUND | round bookkeeping
  // ADDKEY    | end-of-step AddRoundKey, 16 nibble shifts
  // NEXTSTEP  | step bookkeeping, last one returns to IDLE
  typedef enum logic [2:0] {
    IDLE, INIT, SBOX, SHIFTROW, MIXCOL, NEXTROUND, ADDKEY, NEXTSTEP
  } fsm_t;

  fsm_t                fsm, fsm_nxt;
  logic [63:0]         st;
  logic [KEY_BITS-1:0] key;
  logic [5:0]          rc;
  logic [3:0]          cnt;
  logic [1:0]          col;
  logic [1:0]          rnd;
  logic [3:0]          stp;
  logic [3:0]          sb_in;
  logic [3:0]          mc_new;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] gm2(input logic [3:0] d);
    return {d[2], d[1], d[3] ^ d[0], d[3]};
  endfunction

  // idx is the row-major nibble position currently sitting at (0,0)
  function automatic logic [3:0] rcon(input logic [3:0] idx, input logic [5:0] r);
    logic [3:0] c;
    case (idx[1:0])
      2'd0: begin
        case (idx[3:2])
          2'd0:    c = KS[7:4];
          2'd1:    c = KS[7:4] ^ 4'h1;
          2'd2:    c = KS[3:0] ^ 4'h2;
          default: c = KS[3:0] ^ 4'h3;
        endcase
      end
      2'd1:    c = idx[2] ? {1'b0, r[2:0]} : {1'b0, r[5:3]};
      default: c = 4'h0;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] rotl1(input logic [15:0] x);
    return {x[11:0], x[15:12]};
  endfunction

  assign sb_in  = st[63:60] ^ rcon(~cnt, rc);
  assign mc_new = gm2(gm2(st[63:60])) ^ st[47:44] ^ gm2(st[31:28]) ^ gm2(st[15:12]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm <= IDLE;
    else          fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:      if (start) fsm_nxt = INIT;
      INIT:      if (cnt == 4'd0) fsm_nxt = SBOX;
      SBOX:      if (cnt == 4'd0) fsm_nxt = SHIFTROW;
      SHIFTROW:  fsm_nxt = MIXCOL;
      MIXCOL:    if (cnt == 4'd0 && col == 2'd3) fsm_nxt = NEXTROUND;
      NEXTROUND: fsm_nxt = (rnd == 2'd3) ? ADDKEY : SBOX;
      ADDKEY:    if (cnt == 4'd0) fsm_nxt = NEXTSTEP;
      NEXTSTEP:  fsm_nxt = (stp == LAST_STEP) ? IDLE : SBOX;
      default:   fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (fsm != IDLE);
    dataq = st[63 -: SERIAL_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st   <= '0;
      key  <= '0;
      rc   <= 6'h01;
      cnt  <= '0;
      col  <= '0;
      rnd  <= '0;
      stp  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          rc <= 6'h01;
          if (start) begin
            err <= 1'b0;
            cnt <= 4'd15;
            col <= '0;
            rnd <= '0;
            stp <= '0;
          end else if (loadkey) begin
            key <= {key[KEY_BITS-SERIAL_W-1:0], keyi};
          end else if (loadpt) begin
            st <= {st[63-SERIAL_W:0], datai};
          end else if (getct) begin
            st <= {st[63-SERIAL_W:0], {SERIAL_W{1'b0}}};
          end
        end
        INIT, ADDKEY: begin
          st  <= {st[59:0], st[63:60] ^ key[KEY_BITS-1 -: 4]};
          key <= {key[KEY_BITS-5:0], key[KEY_BITS-1 -: 4]};
          cnt <= cnt - 4'd1;
        end
        SBOX: begin
          st  <= {st[59:0], sbox(sb_in)};
          cnt <= cnt - 4'd1;
        end
        SHIFTROW: begin
          st  <= {st[63:48], st[43:32], st[47:44], st[23:16], st[31:24],
                  st[3:0], st[15:4]};
          rc  <= {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
          cnt <= 4'd4;
          col <= '0;
        end
        MIXCOL: begin
          if (cnt != 4'd0) begin
            st  <= {st[47:44], st[59:48], st[31:28], st[43:32], st[15:12], st[27:16],
                    mc_new, st[11:0]};
            cnt <= cnt - 4'd1;
          end else begin
            st  <= {rotl1(st[63:48]), rotl1(st[47:32]), rotl1(st[31:16]), rotl1(st[15:0])};
            cnt <= 4'd4;
            col <= col + 2'd1;
          end
        end
        NEXTROUND: begin
          rnd <= rnd + 2'd1;
          cnt <= 4'd15;
        end
        NEXTSTEP: begin
          stp <= stp + 4'd1;
          cnt <= 4'd15;
          if (stp == LAST_STEP) done <= 1'b1;
        end
        default: ;
      endcase
      if (busy && (start || loadkey || loadpt || getct)) err <= 1'b1;
    end
  end

`ifdef LED_BLOCK_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             blk_cnt <= '0;
    else if (fsm == NEXTSTEP && stp == LAST_STEP) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_led_serial_param.sv
// Directed scoreboard bench for led_serial_param: LED-64/SW1, LED-64/SW4, LED-128/SW8.
module tb_led_serial_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keyi, datai;
  logic       loadkey, loadpt, getct, start;
  int         sel;

  logic [0:0] dq_a;
  logic [3:0] dq_b;
  logic [7:0] dq_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;
  logic       busy_m, done_m, err_m;
  logic [7:0] dq_m;
`ifdef LED_BLOCK_CNT_EN
  logic [15:0] blk_a, blk_b, blk_c, blk_m;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_blk [3];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  led_serial_param #(.KEY_BITS(64), .SERIAL_W(1)) u_a (
    .clk(clk), .reset_n(reset_n), .keyi(keyi[0:0]), .datai(datai[0:0]), .dataq(dq_a),
    .loadkey(loadkey && sel == 0), .loadpt(loadpt && sel == 0), .getct(getct && sel == 0),
    .start(start && sel == 0), .busy(busy_a), .done(done_a), .err(err_a)
`ifdef LED_BLOCK_CNT_EN
    , .blk_cnt(blk_a)
`endif
  );

  led_serial_param #(.KEY_BITS(64), .SERIAL_W(4)) u_b (
    .clk(clk), .reset_n(reset_n), .keyi(keyi[3:0]), .datai(datai[3:0]), .dataq(dq_b),
    .loadkey(loadkey && sel == 1), .loadpt(loadpt && sel == 1), .getct(getct && sel == 1),
    .start(start && sel == 1), .busy(busy_b), .done(done_b), .err(err_b)
`ifdef LED_BLOCK_CNT_EN
    , .blk_cnt(blk_b)
`endif
  );

  led_serial_param #(.KEY_BITS(128), .SERIAL_W(8)) u_c (
    .clk(clk), .reset_n(reset_n), .keyi(keyi), .datai(datai), .dataq(dq_c),
    .loadkey(loadkey && sel == 2), .loadpt(loadpt && sel == 2), .getct(getct && sel == 2),
    .start(start && sel == 2), .busy(busy_c), .done(done_c), .err(err_c)
`ifdef LED_BLOCK_CNT_EN
    , .blk_cnt(blk_c)
`endif
  );

  always_comb begin
    busy_m = busy_a;
    done_m = done_a;
    err_m  = err_a;
    dq_m   = {7'b0, dq_a};
    case (sel)
      1: begin busy_m = busy_b; done_m = done_b; err_m = err_b; dq_m = {4'b0, dq_b}; end
      2: begin busy_m = busy_c; done_m = done_c; err_m = err_c; dq_m = dq_c; end
      default: ;
    endcase
`ifdef LED_BLOCK_CNT_EN
    blk_m = (sel == 1) ? blk_b : (sel == 2) ? blk_c : blk_a;
`endif
  end

  function automatic int sw_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 8;
  endfunction

  function automatic int kb_of(input int s);
    return (s == 2) ? 128 : 64;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int sw = sw_of(sel);
    int kb = kb_of(sel);
    logic [127:0] t = (kb == 64) ? {k[63:0], 64'h0} : k;
    for (int i = 0; i < kb / sw; i++) begin
      keyi    = t[127:120] >> (8 - sw);
      loadkey = 1'b1;
      t       = t << sw;
      tick();
    end
    loadkey = 1'b0;
    keyi    = '0;
  endtask

  task automatic load_pt(input logic [63:0] p);
    int sw = sw_of(sel);
    logic [63:0] t = p;
    for (int i = 0; i < 64 / sw; i++) begin
      datai  = t[63:56] >> (8 - sw);
      loadpt = 1'b1;
      t      = t << sw;
      tick();
    end
    loadpt = 1'b0;
    datai  = '0;
  endtask

  // mode: 0 normal, 1 commands while busy, 2 reset at cycle 500, 3 loadkey alongside start
  task automatic run_enc(input logic [63:0] exp_ct, input int exp_cyc, input int mode);
    int n, busy_cnt;
    bit got, aborted, saw;
    exp_q.push_back((mode == 2) ? 64'h0 : exp_ct);
    start = 1'b1;
    if (mode == 3) begin loadkey = 1'b1; keyi = 8'hFF; end
    tick();
    start = 1'b0; loadkey = 1'b0; keyi = '0;
    chk("busy_on_start", busy_m, 1);
    chk("err_clear_on_start", err_m, 0);
    n = 1; busy_cnt = 0; got = 0; aborted = 0;
    while (n < 4000 && !got && !aborted) begin
      if (done_m) got = 1;
      else begin
        if (busy_m) busy_cnt++;
        if (mode == 1 && n == 100) begin
          loadpt = 1'b1; datai = 8'hFF; start = 1'b1; loadkey = 1'b1; keyi = 8'hFF; getct = 1'b1;
        end
        if (mode == 1 && n == 101) begin
          loadpt = 1'b0; datai = '0; start = 1'b0; loadkey = 1'b0; keyi = '0; getct = 1'b0;
        end
        if (mode == 1 && n == 102) chk("err_set_when_busy", err_m, 1);
        if (mode == 2 && n == 500) begin
          reset_n = 1'b0;
          #1;
          chk("abort_busy", busy_m, 0);
          chk("abort_dataq", dq_m, 0);
          chk("abort_done", done_m, 0);
          tick();
          reset_n = 1'b1;
          for (int i = 0; i < 3; i++) exp_blk[i] = 0;
          saw = 0;
          for (int i = 0; i < 1500; i++) begin
            if (done_m || busy_m) saw = 1;
            tick();
          end
          chk("no_done_after_abort", saw, 0);
          aborted = 1;
        end
        if (!aborted) begin
          tick();
          n++;
        end
      end
    end
    if (!aborted) begin
      chk("done_seen", got, 1);
      chk("done_latency", n - 1, exp_cyc);
      chk("busy_length", busy_cnt, exp_cyc);
      chk("busy_low_at_done", busy_m, 0);
      exp_blk[sel]++;
    end
`ifdef LED_BLOCK_CNT_EN
    chk("blk_cnt", blk_m, exp_blk[sel]);
`endif
  endtask

  task automatic unload();
    int sw = sw_of(sel);
    logic [63:0] ct = '0;
    logic [63:0] exp;
    for (int i = 0; i < 64 / sw; i++) begin
      ct = (ct << sw) | 64'(dq_m);
      if (i == 1) chk("done_one_cycle", done_m, 0);
      getct = 1'b1;
      tick();
    end
    getct = 1'b0;
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("ciphertext", ct, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    keyi = '0; datai = '0; loadkey = 0; loadpt = 0; getct = 0; start = 0;
    sel = 0;
    for (int i = 0; i < 3; i++) exp_blk[i] = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_busy", busy_m, 0);
      chk("reset_done", done_m, 0);
      chk("reset_err", err_m, 0);
      chk("reset_dataq", dq_m, 0);
    end
    tick();

    sel = 0;
    load_key(128'h0); load_pt(64'h0);
    run_enc(64'h39C2401003A0C798, 1368, 0);
    unload();

    sel = 1;
    load_key(128'h0123456789ABCDEF); load_pt(64'h0123456789ABCDEF);
    run_enc(64'hA003551E3893FC58, 1368, 0);
    unload();

    sel = 2;
    load_key(128'h0); load_pt(64'h0);
    run_enc(64'h3DECB2A0850CDBA1, 2044, 1);
    chk("err_sticky_after_done", err_m, 1);
    unload();
    chk("err_sticky_idle", err_m, 1);
    load_pt(64'h0);
    run_enc(64'h3DECB2A0850CDBA1, 2044, 0);
    unload();

    sel = 0;
    load_pt(64'h0);
    run_enc(64'h39C2401003A0C798, 1368, 3);
    unload();

    load_pt(64'h0);
    run_enc(64'h39C2401003A0C798, 1368, 2);
    chk("err_after_reset", err_m, 0);
    unload();
    load_pt(64'h0);
    run_enc(64'h39C2401003A0C798, 1368, 0);
    unload();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
